// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: wraps a valid/ready/last byte stream into an Ethernet
// frame (preamble, SFD, padding, CRC-32 FCS) and enforces the inter-frame gap.
module gmii_tx_framer #(
   parameter int unsigned IFG_CYCLES  = 12,
   parameter int unsigned MIN_PAYLOAD = 60
) (
   input  logic       gmii_clk,
   input  logic       rst_n,
   input  logic       s_valid,
   input  logic [7:0] s_data,
   input  logic       s_last,
   output logic       s_ready,
   output logic       gmii_txd_valid,
   output logic [7:0] gmii_txd_data,
   output logic       busy,
   output logic       frame_done,
   output logic       tx_underrun
);

   typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, DATA, PAD, FCS, DRAIN, IFG} state_t;

   localparam logic [15:0] MIN_LEN  = 16'(MIN_PAYLOAD);
   localparam logic [7:0]  IFG_LAST = 8'(IFG_CYCLES - 1);

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'd0, d};
      for (int unsigned i = 0; i < 8; i++) begin
         r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      end
      return r;
   endfunction

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [15:0] len_q, len_d;
   logic [31:0] crc_q, crc_d;
   // Two register stages between state and pins: a staging byte, then the pins.
   logic        tx_valid_q, tx_valid_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic        tx_done_q, tx_done_d;
   logic        tx_urun_q, tx_urun_d;
   logic        out_valid_q, out_valid_d;
   logic [7:0]  out_data_q, out_data_d;
   logic        out_done_q, out_done_d;
   logic        out_urun_q, out_urun_d;

   logic [15:0] len_inc;
   logic [31:0] crc_inv;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      len_d      = len_q;
      crc_d      = crc_q;
      tx_valid_d = 1'b0;
      tx_data_d  = '0;
      tx_done_d  = 1'b0;
      tx_urun_d  = 1'b0;
      s_ready    = (state_q == DATA) || (state_q == DRAIN);
      busy       = (state_q != IDLE);
      len_inc    = (len_q == '1) ? len_q : len_q + 16'd1;
      crc_inv    = ~crc_q;

      case (state_q)
         IDLE: begin
            if (s_valid) begin
               state_d = PREAMBLE;
               cnt_d   = '0;
               len_d   = '0;
               crc_d   = '1;
            end
         end
         PREAMBLE: begin
            tx_valid_d = 1'b1;
            tx_data_d  = 8'h55;
            if (cnt_q == 8'd6) state_d = SFD;
            else               cnt_d   = cnt_q + 8'd1;
         end
         SFD: begin
            tx_valid_d = 1'b1;
            tx_data_d  = 8'hD5;
            state_d    = DATA;
         end
         DATA: begin
            if (s_valid) begin
               tx_valid_d = 1'b1;
               tx_data_d  = s_data;
               crc_d      = crc_byte(crc_q, s_data);
               len_d      = len_inc;
               if (s_last) begin
                  cnt_d   = '0;
                  state_d = (len_inc < MIN_LEN) ? PAD : FCS;
               end
            end else begin
               // Starved mid-frame: abandon the frame and swallow the rest.
               tx_urun_d = 1'b1;
               state_d   = DRAIN;
            end
         end
         PAD: begin
            tx_valid_d = 1'b1;
            crc_d      = crc_byte(crc_q, 8'h00);
            len_d      = len_inc;
            if (len_inc >= MIN_LEN) begin
               cnt_d   = '0;
               state_d = FCS;
            end
         end
         FCS: begin
            tx_valid_d = 1'b1;
            tx_data_d  = crc_inv[{cnt_q[1:0], 3'b000} +: 8];
            if (cnt_q == 8'd3) begin
               tx_done_d = 1'b1;
               cnt_d     = '0;
               state_d   = IFG;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         DRAIN: begin
            if (s_valid && s_last) begin
               cnt_d   = '0;
               state_d = IFG;
            end
         end
         IFG: begin
            if (cnt_q == IFG_LAST) state_d = IDLE;
            else                   cnt_d   = cnt_q + 8'd1;
         end
         default: state_d = IDLE;
      endcase

      out_valid_d = tx_valid_q;
      out_data_d  = tx_data_q;
      out_done_d  = tx_done_q;
      out_urun_d  = tx_urun_q;
   end

   always_ff @(posedge gmii_clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         len_q       <= '0;
         crc_q       <= '1;
         tx_valid_q  <= 1'b0;
         tx_data_q   <= '0;
         tx_done_q   <= 1'b0;
         tx_urun_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_done_q  <= 1'b0;
         out_urun_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         len_q       <= len_d;
         crc_q       <= crc_d;
         tx_valid_q  <= tx_valid_d;
         tx_data_q   <= tx_data_d;
         tx_done_q   <= tx_done_d;
         tx_urun_q   <= tx_urun_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_done_q  <= out_done_d;
         out_urun_q  <= out_urun_d;
      end
   end

   assign gmii_txd_valid = out_valid_q;
   assign gmii_txd_data  = out_data_q;
   assign frame_done     = out_done_q;
   assign tx_underrun    = out_urun_q;

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Self-checking bench for gmii_tx_framer: table of directed frames plus
// hand-written back-to-back and mid-frame reset sequences.
module tb_gmii_tx_framer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       sv  [2];
   logic [7:0] sd  [2];
   logic       sl  [2];
   logic       rdy [2];
   logic       gv  [2];
   logic [7:0] gd  [2];
   logic       bsy [2];
   logic       fd  [2];
   logic       ur  [2];

   always #4 clk = ~clk;

   // Instance 0: default padding; instance 1: padding disabled.
   gmii_tx_framer #(.IFG_CYCLES(12), .MIN_PAYLOAD(60)) dut (
      .gmii_clk(clk), .rst_n(rst_n), .s_valid(sv[0]), .s_data(sd[0]), .s_last(sl[0]),
      .s_ready(rdy[0]), .gmii_txd_valid(gv[0]), .gmii_txd_data(gd[0]), .busy(bsy[0]),
      .frame_done(fd[0]), .tx_underrun(ur[0]));

   gmii_tx_framer #(.IFG_CYCLES(12), .MIN_PAYLOAD(0)) dut_nopad (
      .gmii_clk(clk), .rst_n(rst_n), .s_valid(sv[1]), .s_data(sd[1]), .s_last(sl[1]),
      .s_ready(rdy[1]), .gmii_txd_valid(gv[1]), .gmii_txd_data(gd[1]), .busy(bsy[1]),
      .frame_done(fd[1]), .tx_underrun(ur[1]));

   typedef struct {
      int          d;
      int          len;
      logic [7:0]  base;
      int          drop;
      int          exp_valid;
      int          exp_done;
      int          exp_urun;
      logic [31:0] exp_fcs;
   } vec_t;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int start_cyc;

   logic [7:0] pay [4096];
   logic [7:0] rx  [2][4096];
   int  rx_n     [2] = '{0, 0};
   int  done_cnt [2] = '{0, 0};
   int  done_idx [2] = '{-1, -1};
   int  urun_cnt [2] = '{0, 0};
   int  runs     [2] = '{0, 0};
   int  low_run  [2] = '{0, 0};
   int  last_gap [2] = '{-1, -1};
   int  rise_cyc [2] = '{-1, -1};
   logic prev_v  [2] = '{1'b0, 1'b0};

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (gv[d] === 1'b1) begin
            if (!prev_v[d]) begin
               runs[d]++;
               rise_cyc[d] = cyc;
               last_gap[d] = low_run[d];
            end
            if (rx_n[d] < 4096) rx[d][rx_n[d]] = gd[d];
            rx_n[d]++;
            low_run[d] = 0;
         end else begin
            low_run[d]++;
         end
         if (fd[d] === 1'b1) begin
            done_cnt[d]++;
            done_idx[d] = (gv[d] === 1'b1) ? rx_n[d] : -1;
         end
         if (ur[d] === 1'b1) urun_cnt[d]++;
         prev_v[d] = (gv[d] === 1'b1);
      end
   end

   task automatic chk(input string nm, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c;
      for (int k = 0; k < 8; k++) begin
         if (r[0] ^ b[k]) r = (r >> 1) ^ 32'hEDB88320;
         else             r = r >> 1;
      end
      return r;
   endfunction

   task automatic send(input int d, input int len, input int drop, input bit hold);
      int  i;
      int  guard;
      bit  dropped;
      bit  acc;
      i = 0; guard = 0; dropped = 0;
      start_cyc = cyc + 1;
      while (i < len && guard < 4000) begin
         if (i == drop && !dropped) begin
            sv[d] = 1'b0;
            sl[d] = 1'b0;
            dropped = 1'b1;
         end else begin
            sv[d] = 1'b1;
            sd[d] = pay[i];
            sl[d] = (i == len - 1);
         end
         @(negedge clk);
         acc = sv[d] && rdy[d];
         @(posedge clk); #1;
         if (acc) i++;
         guard++;
      end
      chk("send_accepted", i, len);
      if (!hold) begin
         sv[d] = 1'b0;
         sl[d] = 1'b0;
      end
   endtask

   task automatic wait_idle(input int d);
      int g;
      g = 0;
      @(negedge clk);
      while (bsy[d] && g < 5000) begin
         @(negedge clk);
         g++;
      end
      chk("idle_reached", bsy[d], 0);
      repeat (4) @(negedge clk);
      @(posedge clk); #1;
   endtask

   task automatic check_frame(input int d, input int off, input int plen, input int tot,
                              input bit has_fcs);
      int e_pre, e_pay, e_pad;
      logic [31:0] c;
      e_pre = 0; e_pay = 0; e_pad = 0;
      for (int i = 0; i < 7; i++) if (rx[d][off+i] != 8'h55) e_pre++;
      if (rx[d][off+7] != 8'hD5) e_pre++;
      for (int i = 0; i < plen; i++) if (rx[d][off+8+i] != pay[i]) e_pay++;
      chk("preamble_sfd_errs", e_pre, 0);
      chk("payload_errs", e_pay, 0);
      if (has_fcs) begin
         for (int i = off + 8 + plen; i < off + tot - 4; i++) if (rx[d][i] != 8'h00) e_pad++;
         chk("pad_errs", e_pad, 0);
         c = '1;
         for (int i = off + 8; i < off + tot; i++) c = crc_upd(c, rx[d][i]);
         chk("fcs_residue", c, 32'hDEBB20E3);
      end
   endtask

   task automatic run_vec(input vec_t v, input int n);
      int b_rx, b_done, b_urun, b_runs;
      logic [31:0] fcs;
      for (int i = 0; i < v.len; i++) pay[i] = v.base + 8'(i);
      b_rx = rx_n[v.d]; b_done = done_cnt[v.d]; b_urun = urun_cnt[v.d]; b_runs = runs[v.d];
      send(v.d, v.len, v.drop, 1'b0);
      wait_idle(v.d);
      chk($sformatf("v%0d_valid_cycles", n), rx_n[v.d] - b_rx, v.exp_valid);
      chk($sformatf("v%0d_frame_done", n), done_cnt[v.d] - b_done, v.exp_done);
      chk($sformatf("v%0d_underrun", n), urun_cnt[v.d] - b_urun, v.exp_urun);
      chk($sformatf("v%0d_valid_runs", n), runs[v.d] - b_runs, 1);
      chk($sformatf("v%0d_latency", n), rise_cyc[v.d] - start_cyc, 2);
      if (v.exp_done != 0) begin
         chk($sformatf("v%0d_done_pos", n), done_idx[v.d] - b_rx, v.exp_valid);
         check_frame(v.d, b_rx, v.len, v.exp_valid, 1'b1);
         if (v.exp_fcs != 0) begin
            fcs = {rx[v.d][b_rx+v.exp_valid-1], rx[v.d][b_rx+v.exp_valid-2],
                   rx[v.d][b_rx+v.exp_valid-3], rx[v.d][b_rx+v.exp_valid-4]};
            chk($sformatf("v%0d_fcs", n), fcs, v.exp_fcs);
         end
      end else begin
         check_frame(v.d, b_rx, v.drop, v.exp_valid, 1'b0);
      end
   endtask

   vec_t vecs [9];
   vec_t post_rst;

   initial begin
      int b_rx, b_done, g;

      vecs[0] = '{1, 9,    8'h31, -1, 21,   1, 0, 32'hCBF43926};
      vecs[1] = '{0, 10,   8'h01, -1, 72,   1, 0, 32'h0};
      vecs[2] = '{0, 60,   8'h80, -1, 72,   1, 0, 32'h0};
      vecs[3] = '{0, 61,   8'h10, -1, 73,   1, 0, 32'h0};
      vecs[4] = '{0, 1,    8'hA5, -1, 72,   1, 0, 32'h0};
      vecs[5] = '{1, 1,    8'h5A, -1, 13,   1, 0, 32'h0};
      vecs[6] = '{0, 40,   8'h20, 20, 28,   0, 1, 32'h0};
      vecs[7] = '{0, 64,   8'h00, -1, 76,   1, 0, 32'h0};
      vecs[8] = '{0, 1500, 8'h07, -1, 1512, 1, 0, 32'h0};
      post_rst = '{0, 64, 8'hC3, -1, 76, 1, 0, 32'h0};

      rst_n = 1'b0;
      for (int d = 0; d < 2; d++) begin
         sv[d] = 1'b0; sd[d] = 8'h00; sl[d] = 1'b0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", gv[0], 0);
      chk("rst_data", gd[0], 0);
      chk("rst_ready", rdy[0], 0);
      chk("rst_busy", bsy[0], 0);
      chk("rst_frame_done", fd[0], 0);
      chk("rst_underrun", ur[0], 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk); #1;

      for (int n = 0; n < 9; n++) run_vec(vecs[n], n);

      // Two 64-byte frames with s_valid never dropping between them.
      for (int i = 0; i < 64; i++) pay[i] = 8'hE0 + 8'(i);
      b_rx = rx_n[0]; b_done = done_cnt[0];
      send(0, 64, -1, 1'b1);
      send(0, 64, -1, 1'b0);
      wait_idle(0);
      chk("b2b_valid_cycles", rx_n[0] - b_rx, 152);
      chk("b2b_frame_done", done_cnt[0] - b_done, 2);
      chk("b2b_gap", last_gap[0], 13);
      check_frame(0, b_rx, 64, 76, 1'b1);
      check_frame(0, b_rx + 76, 64, 76, 1'b1);

      // Reset while the FCS is going out.
      for (int i = 0; i < 60; i++) pay[i] = 8'h40 + 8'(i);
      b_rx = rx_n[0]; b_done = done_cnt[0];
      send(0, 60, -1, 1'b0);
      g = 0;
      @(negedge clk);
      while (rx_n[0] - b_rx < 70 && g < 200) begin
         @(negedge clk);
         g++;
      end
      chk("rst_mid_reached_fcs", rx_n[0] - b_rx, 70);
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst_mid_valid", gv[0], 0);
      chk("rst_mid_data", gd[0], 0);
      chk("rst_mid_busy", bsy[0], 0);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("rst_mid_no_done", done_cnt[0] - b_done, 0);
      chk("rst_mid_no_more_bytes", rx_n[0] - b_rx, 71);
      @(posedge clk); #1;
      run_vec(post_rst, 9);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
